// File: rtl/fixedp_tc2sm_stream.sv
// Two's-complement to sign-magnitude converter with a 2-stage valid/ready pipeline.
// The most negative input saturates to the largest magnitude; saturated deliveries are counted.
module fixedp_tc2sm_stream #(
    parameter int unsigned Q = 15,
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  sat_count
);

    localparam int unsigned CNT_W = 16;

    // Q only scales the value; it must still fit inside the magnitude field.
    if (N < 4 || Q > N - 1) begin : g_param_check
        $error("fixedp_tc2sm_stream: requires N >= 4 and Q <= N-1");
    end

    typedef struct packed {
        logic         sat;
        logic [N-1:0] data;
    } word_t;

    logic         s1_valid;
    word_t        s1_word;
    word_t        out_word;
    word_t        conv_word;
    logic [N-1:0] neg_data;
    logic         is_min;
    logic         s1_ready;
    logic         s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    assign out_data = out_word.data;
    assign out_sat  = out_word.sat;

    assign neg_data = (~in_data) + N'(1);
    assign is_min   = (in_data == {1'b1, {(N-1){1'b0}}});

    // Sign/abs conversion; negative inputs always have a non-zero magnitude, so no -0.
    always_comb begin
        conv_word.sat  = 1'b0;
        conv_word.data = {1'b0, in_data[N-2:0]};
        if (in_data[N-1]) begin
            if (is_min) begin
                conv_word.sat  = 1'b1;
                conv_word.data = '1;
            end else begin
                conv_word.data = {1'b1, neg_data[N-2:0]};
            end
        end
    end

    // Stage 1: converted word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_word <= conv_word;
            end
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_word <= s1_word;
            end
        end
    end

    // Saturated-delivery counter, sticks at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_word.sat && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fixedp_tc2sm_stream.sv
// Scoreboard bench for fixedp_tc2sm_stream: directed vectors, backpressure, counter saturation,
// asynchronous reset mid-stream and a randomized valid/ready stream against an arithmetic model.
module tb_fixedp_tc2sm_stream;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_sat;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  sat_count;

    int checks = 0;
    int errors = 0;

    logic [N:0]   sb_q[$];
    logic [15:0]  exp_cnt = 16'd0;
    logic         stalled = 1'b0;
    logic [N:0]   held    = '0;

    fixedp_tc2sm_stream #(.Q(15), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value as a signed integer, then sign and absolute value; {sat, word}.
    function automatic logic [N:0] ref_conv(input logic [N-1:0] d);
        longint v;
        longint mag;
        logic [63:0] m;
        v = longint'($signed(d));
        if (v == -(longint'(1) <<< (N - 1))) return {1'b1, {N{1'b1}}};
        mag = (v < 0) ? -v : v;
        m = 64'(mag);
        return {1'b0, (v < 0), m[N-2:0]};
    endfunction

    function automatic logic [N-1:0] pick_data();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Stimulus side of the scoreboard: every accepted input enqueues its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) sb_q.push_back(ref_conv(in_data));
    end

    // Monitor: compares delivered words, stall stability and the saturation counter.
    always @(negedge clk) begin
        logic [N:0] exp_w;
        if (!rst_n) begin
            sb_q.delete();
            exp_cnt = 16'd0;
            stalled = 1'b0;
        end else begin
            chk("sat_count", 64'(sat_count), 64'(exp_cnt));
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_word", 64'({out_sat, out_data}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h expected no word at %0t", {out_sat, out_data}, $time);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("out_word", 64'({out_sat, out_data}), 64'(exp_w));
                    if (exp_w[N] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_sat, out_data};
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated word through an empty pipeline with out_ready high.
    task automatic directed(input logic [N-1:0] d, input logic [N-1:0] exp_d, input logic exp_s);
        in_data  = d;
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("lat_s1_only", 64'(out_valid), 64'd0);
        next_cycle();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("dir_data", 64'(out_data), 64'(exp_d));
        chk("dir_sat", 64'(out_sat), 64'(exp_s));
        next_cycle();
    endtask

    initial begin
        int idx;
        int cyc;
        int blocked;
        int acc;
        logic saw_block;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        directed(32'h0000_8000, 32'h0000_8000, 1'b0);
        directed(32'hFFFF_8000, 32'h8000_8000, 1'b0);
        directed(32'h0000_0000, 32'h0000_0000, 1'b0);
        directed(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        directed(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("sat_count_one", 64'(sat_count), 64'd1);
        directed(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        directed(32'h8000_0001, 32'hFFFF_FFFF, 1'b0);

        // Stream 1..5 with out_ready dropped for cycles 3-6.
        idx = 0;
        saw_block = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            in_valid  = (idx < 5);
            in_data   = 32'(idx + 1);
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (in_valid && !in_ready) saw_block = 1'b1;
            next_cycle();
            if (idx == 5 && sb_q.size() == 0 && !out_valid) break;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(idx), 64'd5);
        chk("bp_in_ready_low", 64'(saw_block), 64'd1);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);

        // Full-rate stream of most-negative words drives the counter into saturation.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000;
        blocked   = 0;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if (!in_ready) blocked++;
            next_cycle();
        end
        in_valid = 1'b0;
        repeat (4) next_cycle();
        chk("sat_count_max", 64'(sat_count), 64'hFFFF);
        chk("full_rate_stalls", 64'(blocked), 64'd0);

        // Two words buffered, then asynchronous reset mid-cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000;
        next_cycle();
        in_data   = 32'h0000_0005;
        next_cycle();
        in_valid  = 1'b0;
        chk("buf_full_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_out_sat", 64'(out_sat), 64'd0);
        chk("arst_sat_count", 64'(sat_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_ghost_word", 64'(out_valid), 64'd0);
            next_cycle();
        end

        // Randomized valid/ready stream.
        acc = 0;
        for (int i = 0; i < 20000 && acc < 2000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = pick_data();
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", 64'(acc), 64'd2000);
        for (int i = 0; i < 10 && (sb_q.size() != 0 || out_valid); i++) next_cycle();
        chk("rand_drained", 64'(sb_q.size()), 64'd0);
        chk("rand_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
